switch_reverse_bank: RTL and testbench

Parametrised multi-switch reverse manager for the edit-mode key path. One active-low push key drives two gestures while EditMode is high: a short press steps a selection pointer across NUM_SW switches with wrap-around, and a long press toggles the reverse flag of the selected switch. Fully synchronous to clk: the key is synchronised and debounced and is never used as a clock or asynchronous control. Sits between the key/edit-mode logic and the display/switch-decode logic, replacing the single-flag reverse manager.

---
 rtl/switch_reverse_bank.sv | 145 ++++++++++++++
 tb/tb_switch_reverse_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_reverse_bank.sv
// Multi-switch reverse manager: a debounced active-low key steps a selection
// pointer on short presses and toggles the selected reverse flag on long presses.
module switch_reverse_bank #(
  parameter int NUM_SW       = 8,
  parameter int SEL_W        = $clog2(NUM_SW),
  parameter int TICK_CYCLES  = 50_000_000,
  parameter int HOLD_SECONDS = 2,
  parameter int DEB_CYCLES   = 500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              KeySwi,
  input  logic              EditMode,
  output logic [NUM_SW-1:0] SwiReverse,
  output logic [SEL_W-1:0]  SwiSel,
  output logic              LongHeld,
  output logic              ToggleStb
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_LONG  = 2'd2;

  localparam logic [31:0]      DEB_LAST  = 32'(DEB_CYCLES - 1);
  localparam logic [31:0]      TICK_LAST = 32'(TICK_CYCLES - 1);
  localparam logic [2:0]       SEC_LAST  = 3'(HOLD_SECONDS - 1);
  localparam logic [2:0]       SEC_MAX   = 3'(HOLD_SECONDS);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_SW - 1);

  logic              r_sync1;
  logic              r_ks;
  logic              r_kdb;
  logic              r_kdb_d;
  logic [31:0]       r_deb_cnt;
  logic [1:0]        r_state;
  logic [31:0]       r_tick;
  logic [2:0]        r_sec;
  logic [NUM_SW-1:0] r_rev;
  logic [SEL_W-1:0]  r_sel;
  logic              r_stb;

  logic              w_kfall;
  logic              w_krise;
  logic              w_tick_wrap;
  logic              w_reach_long;
  logic [NUM_SW-1:0] w_sel_mask;

  // Synchroniser and debouncer; everything idles at the released level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_ks      <= 1'b1;
      r_kdb     <= 1'b1;
      r_kdb_d   <= 1'b1;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= KeySwi;
      r_ks    <= r_sync1;
      r_kdb_d <= r_kdb;
      if (r_ks == r_kdb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_kdb     <= r_ks;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 32'd1;
      end
    end
  end

  assign w_kfall      = r_kdb_d & ~r_kdb;
  assign w_krise      = ~r_kdb_d & r_kdb;
  assign w_tick_wrap  = (r_tick == TICK_LAST);
  assign w_reach_long = w_tick_wrap && (r_sec == SEC_LAST);
  assign w_sel_mask   = {{(NUM_SW-1){1'b0}}, 1'b1} << r_sel;

  // Gesture FSM: EditMode dropping beats release, and release beats the long threshold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_sec   <= '0;
      r_rev   <= '0;
      r_sel   <= '0;
      r_stb   <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_kfall && EditMode) begin
            r_state <= S_PRESS;
            r_tick  <= '0;
            r_sec   <= '0;
          end
        end
        S_PRESS: begin
          if (!EditMode) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_sec   <= '0;
          end else if (w_krise) begin
            r_sel   <= (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_sec   <= '0;
          end else begin
            if (w_tick_wrap) begin
              r_tick <= '0;
              r_sec  <= (r_sec == SEC_MAX) ? SEC_MAX : r_sec + 3'd1;
            end else begin
              r_tick <= r_tick + 32'd1;
            end
            if (w_reach_long) begin
              r_state <= S_LONG;
            end
          end
        end
        S_LONG: begin
          if (!EditMode) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_sec   <= '0;
          end else if (w_krise) begin
            r_rev   <= r_rev ^ w_sel_mask;
            r_stb   <= 1'b1;
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_sec   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
          r_sec   <= '0;
        end
      endcase
    end
  end

  assign SwiReverse = r_rev;
  assign SwiSel     = r_sel;
  assign LongHeld   = (r_state == S_LONG);
  assign ToggleStb  = r_stb;

endmodule

// File: tb/tb_switch_reverse_bank.sv
// Bench for switch_reverse_bank: a time-window behavioural model checked every
// cycle, plus hand-computed expectations for each directed scenario.
module tb_switch_reverse_bank;

  localparam int NSW  = 4;
  localparam int TICK = 10;
  localparam int HOLD = 2;
  localparam int DEB  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           KeySwi;
  logic           EditMode;
  logic [NSW-1:0] SwiReverse;
  logic [1:0]     SwiSel;
  logic           LongHeld;
  logic           ToggleStb;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cnt = 0;

  switch_reverse_bank #(
    .NUM_SW      (NSW),
    .TICK_CYCLES (TICK),
    .HOLD_SECONDS(HOLD),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .KeySwi    (KeySwi),
    .EditMode  (EditMode),
    .SwiReverse(SwiReverse),
    .SwiSel    (SwiSel),
    .LongHeld  (LongHeld),
    .ToggleStb (ToggleStb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model. The debounced level flips once the last DEB synchronised
  // samples all disagree with it; a press becomes long once it has lasted TICK*HOLD edges.
  bit         m_ok = 0;
  int         cyc = 0;
  bit         m_hist [0:DEB+1];
  bit         m_kdb;
  bit         m_fall_q;
  bit         m_rise_q;
  bit         m_active;
  bit         m_long;
  int         m_start;
  logic [3:0] m_rev;
  int         m_sel;
  bit         m_stb;

  always @(posedge clk) begin
    bit kfall, krise, all_diff;
    cyc++;
    if (!reset) begin
      for (int k = 0; k <= DEB + 1; k++) m_hist[k] = 1'b1;
      m_kdb = 1'b1; m_fall_q = 1'b0; m_rise_q = 1'b0;
      m_active = 1'b0; m_long = 1'b0; m_start = 0;
      m_rev = '0; m_sel = 0; m_stb = 1'b0;
      m_ok = 1'b1;
    end else begin
      kfall = m_fall_q;
      krise = m_rise_q;
      for (int k = DEB + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = KeySwi;
      all_diff = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) if (m_hist[k] == m_kdb) all_diff = 1'b0;
      m_fall_q = all_diff && m_kdb;
      m_rise_q = all_diff && !m_kdb;
      if (all_diff) m_kdb = !m_kdb;
      m_stb = 1'b0;
      if (m_active) begin
        if (!EditMode) begin
          m_active = 1'b0;
        end else if (krise) begin
          if (m_long) begin
            m_rev[m_sel] = ~m_rev[m_sel];
            m_stb = 1'b1;
          end else begin
            m_sel = (m_sel + 1) % NSW;
          end
          m_active = 1'b0;
        end else if (!m_long && (cyc - m_start) == TICK * HOLD) begin
          m_long = 1'b1;
        end
      end else if (kfall && EditMode) begin
        m_active = 1'b1;
        m_long   = 1'b0;
        m_start  = cyc;
      end
      if (!m_active) m_long = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (ToggleStb === 1'b1) stb_cnt++;
    if (m_ok) begin
      if (!reset) begin
        check("rst_rev", SwiReverse, 0);
        check("rst_sel", SwiSel, 0);
        check("rst_long", LongHeld, 0);
        check("rst_stb", ToggleStb, 0);
      end else begin
        check("model_rev", SwiReverse, m_rev);
        check("model_sel", SwiSel, m_sel);
        check("model_long", LongHeld, m_long);
        check("model_stb", ToggleStb, m_stb);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int len, input int gap);
    KeySwi = 1'b0;
    tick(len);
    KeySwi = 1'b1;
    tick(gap);
  endtask

  // Holds the key for 'hold' edges and reports after how many edges LongHeld rose.
  task automatic long_press(input int hold, output int rise);
    rise = 0;
    KeySwi = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      tick(1);
      if (rise == 0 && LongHeld === 1'b1) rise = i;
    end
    KeySwi = 1'b1;
    tick(10);
  endtask

  initial begin
    int rise;
    int stb0;
    int sel_steps [5] = '{1, 2, 3, 0, 1};
    reset = 1'b0; KeySwi = 1'b1; EditMode = 1'b0;
    tick(2);
    check("reset_rev", SwiReverse, 0);
    check("reset_sel", SwiSel, 0);
    reset = 1'b1;
    tick(10);
    check("idle_long", LongHeld, 0);
    check("idle_stb_count", stb_cnt, 0);

    // Five short presses walk the pointer with wrap-around.
    EditMode = 1'b1;
    for (int p = 0; p < 5; p++) begin
      press(8, 10);
      check("short_sel", SwiSel, sel_steps[p]);
    end
    check("short_rev", SwiReverse, 0);

    // Long press: key drop -> 2 sync + 3 debounce + 1 kfall + 20 hold = 26 edges.
    stb0 = stb_cnt;
    long_press(40, rise);
    check("long_rise_edge", rise, 26);
    check("long_rev", SwiReverse, 4'b0010);
    check("long_stb_once", stb_cnt - stb0, 1);
    check("long_sel_kept", SwiSel, 1);
    long_press(40, rise);
    check("long2_rev", SwiReverse, 4'b0000);
    check("long2_stb", stb_cnt - stb0, 2);

    // Bounces shorter than the debounce window are rejected.
    repeat (3) begin
      KeySwi = 1'b0; tick(2);
      KeySwi = 1'b1; tick(2);
    end
    tick(10);
    check("bounce_sel", SwiSel, 1);
    check("bounce_long", LongHeld, 0);

    // Abort in PRESS, then a held key after EditMode returns does nothing.
    KeySwi = 1'b0; tick(10);
    EditMode = 1'b0; tick(5);
    EditMode = 1'b1; tick(30);
    check("abort_press_long", LongHeld, 0);
    KeySwi = 1'b1; tick(10);
    check("abort_press_sel", SwiSel, 1);
    press(8, 10);
    check("repress_sel", SwiSel, 2);

    // Abort in LONG.
    stb0 = stb_cnt;
    KeySwi = 1'b0; tick(30);
    check("abort_long_held", LongHeld, 1);
    EditMode = 1'b0; tick(1);
    check("abort_long_drop", LongHeld, 0);
    EditMode = 1'b1; tick(5);
    KeySwi = 1'b1; tick(10);
    check("abort_long_rev", SwiReverse, 0);
    check("abort_long_stb", stb_cnt - stb0, 0);
    check("abort_long_sel", SwiSel, 2);

    // Build SwiReverse = 1000, then reset in the middle of a LONG.
    press(8, 10);
    check("pre_rst_sel", SwiSel, 3);
    long_press(40, rise);
    check("pre_rst_rev", SwiReverse, 4'b1000);
    stb0 = stb_cnt;
    KeySwi = 1'b0; tick(30);
    check("pre_rst_long", LongHeld, 1);
    reset = 1'b0;
    #1;
    check("async_rev", SwiReverse, 0);
    check("async_sel", SwiSel, 0);
    check("async_long", LongHeld, 0);
    check("async_stb", ToggleStb, 0);
    tick(2);
    reset = 1'b1;
    tick(1);
    KeySwi = 1'b1;
    tick(20);
    check("post_rst_stb", stb_cnt - stb0, 0);
    check("post_rst_rev", SwiReverse, 0);
    check("post_rst_sel", SwiSel, 0);
    check("post_rst_long", LongHeld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
